// File: rtl/tick_generator.sv
// tick_generator: divides CLOCK_50M into a base tick and a level-dependent
// fall tick. Both are single-cycle clock enables. Square-wave phase outputs
// are provided for slow-clock consumers.
module tick_generator #(
  parameter int BASE_DIV     = 5000000,
  parameter int BASE_W       = 23,
  parameter int FALL_DIV0    = 10,
  parameter int FALL_DIV_MIN = 1,
  parameter int LEVEL_W      = 4
) (
  input  logic               CLOCK_50M,
  input  logic               reset,
  input  logic               enable,
  input  logic               restart,
  input  logic [LEVEL_W-1:0] level,
  input  logic               soft_drop,
  output logic               base_tick,
  output logic               fall_tick,
  output logic               base_phase,
  output logic               fall_phase
);

  // fall counter only needs to reach FALL_DIV0-1; keep at least one bit
  localparam int FALL_W = (FALL_DIV0 > 1) ? $clog2(FALL_DIV0) : 1;
  // divisor width has one spare bit so div_eff-1 cannot wrap
  localparam int DIV_W  = $clog2(FALL_DIV0 + 1) + 1;
  // comparison width large enough for both the level and the divisor
  localparam int CMP_W  = ((DIV_W > LEVEL_W) ? DIV_W : LEVEL_W) + 1;

  localparam logic [CMP_W-1:0]  HEADROOM  = CMP_W'(FALL_DIV0 - FALL_DIV_MIN);
  localparam logic [CMP_W-1:0]  DIV0_X    = CMP_W'(FALL_DIV0);
  localparam logic [DIV_W-1:0]  DIV_MIN   = DIV_W'(FALL_DIV_MIN);
  localparam logic [BASE_W-1:0] BASE_LAST = BASE_W'(BASE_DIV - 1);

  logic [BASE_W-1:0] r_base_cnt;
  logic [FALL_W-1:0] r_fall_cnt;
  logic [CMP_W-1:0]  w_level_x;
  logic [DIV_W-1:0]  w_div_eff;
  logic              w_base_wrap;
  logic              w_fall_hit;

  assign w_level_x = CMP_W'(level);

  // effective fall divisor: soft drop or a high level clamps to the floor;
  // the subtraction only happens when level is below the headroom, so no underflow
  always_comb begin
    w_div_eff = DIV_MIN;
    if (!soft_drop && (w_level_x < HEADROOM))
      w_div_eff = DIV_W'(DIV0_X - w_level_x);
  end

  assign w_base_wrap = (r_base_cnt == BASE_LAST);
  // >= compare lets a lowered divisor fire on the very next base wrap
  assign w_fall_hit  = (DIV_W'(r_fall_cnt) >= (w_div_eff - DIV_W'(1)));

  // counters, registered tick pulses and phase toggles
  always_ff @(posedge CLOCK_50M or posedge reset) begin
    if (reset) begin
      r_base_cnt <= '0;
      r_fall_cnt <= '0;
      base_tick  <= 1'b0;
      fall_tick  <= 1'b0;
      base_phase <= 1'b0;
      fall_phase <= 1'b0;
    end else if (restart) begin
      r_base_cnt <= '0;
      r_fall_cnt <= '0;
      base_tick  <= 1'b0;
      fall_tick  <= 1'b0;
      base_phase <= 1'b0;
      fall_phase <= 1'b0;
    end else if (enable) begin
      fall_tick <= 1'b0;
      if (w_base_wrap) begin
        r_base_cnt <= '0;
        base_tick  <= 1'b1;
        base_phase <= ~base_phase;
        if (w_fall_hit) begin
          r_fall_cnt <= '0;
          fall_tick  <= 1'b1;
          fall_phase <= ~fall_phase;
        end else begin
          r_fall_cnt <= r_fall_cnt + FALL_W'(1);
        end
      end else begin
        r_base_cnt <= r_base_cnt + BASE_W'(1);
        base_tick  <= 1'b0;
      end
    end else begin
      // paused: counts and phases hold, no pulses, no catch-up later
      base_tick <= 1'b0;
      fall_tick <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tick_generator.sv
// Directed bench for tick_generator with BASE_DIV=4, FALL_DIV0=3, FALL_DIV_MIN=1.
// Edge numbers count rising edges after reset release; outputs are sampled 1ns after each edge.
module tb_tick_generator;

  logic       CLOCK_50M = 1'b0;
  logic       reset     = 1'b1;
  logic       enable    = 1'b0;
  logic       restart   = 1'b0;
  logic [3:0] level     = 4'd0;
  logic       soft_drop = 1'b0;
  logic       base_tick, fall_tick, base_phase, fall_phase;

  int n_chk  = 0;
  int n_pass = 0;

  tick_generator #(
    .BASE_DIV(4), .BASE_W(3), .FALL_DIV0(3), .FALL_DIV_MIN(1), .LEVEL_W(4)
  ) dut (
    .CLOCK_50M (CLOCK_50M),
    .reset     (reset),
    .enable    (enable),
    .restart   (restart),
    .level     (level),
    .soft_drop (soft_drop),
    .base_tick (base_tick),
    .fall_tick (fall_tick),
    .base_phase(base_phase),
    .fall_phase(fall_phase)
  );

  always #5 CLOCK_50M = ~CLOCK_50M;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h, want %0h", tag, act, exp);
    else n_pass++;
  endtask

  // one rising edge, then check both ticks
  task automatic edge_chk(input string tag, input int e, input bit eb, input bit ef);
    @(posedge CLOCK_50M); #1;
    chk($sformatf("%s e%0d base_tick", tag, e), 32'(base_tick), 32'(eb));
    chk($sformatf("%s e%0d fall_tick", tag, e), 32'(fall_tick), 32'(ef));
  endtask

  // reset for one edge, check cleared outputs, release just after the edge
  task automatic do_reset(input string tag);
    reset = 1'b1; enable = 1'b0; restart = 1'b0; soft_drop = 1'b0; level = 4'd0;
    @(posedge CLOCK_50M); #1;
    chk({tag, " rst outs"}, 32'({base_tick, fall_tick, base_phase, fall_phase}), 32'd0);
    reset = 1'b0;
  endtask

  // steady run: base every 4 edges, fall every fe base ticks
  task automatic run_std(input string tag, input int n, input int fe);
    for (int e = 1; e <= n; e++) begin
      bit eb, ef;
      eb = (e % 4 == 0);
      ef = eb && ((e / 4) % fe == 0);
      edge_chk(tag, e, eb, ef);
      if (eb) chk($sformatf("%s e%0d base_phase", tag, e), 32'(base_phase), 32'((e / 4) % 2));
      if (ef) chk($sformatf("%s e%0d fall_phase", tag, e), 32'(fall_phase), 32'((e / (4 * fe)) % 2));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // basic level 0: base at 4,8,12..; fall at 12,24
    do_reset("L0");
    enable = 1'b1;
    run_std("L0", 24, 3);

    // level sweep
    do_reset("L1"); enable = 1'b1; level = 4'd1;  run_std("L1", 16, 2);
    do_reset("L2"); enable = 1'b1; level = 4'd2;  run_std("L2", 8, 1);
    do_reset("L15"); enable = 1'b1; level = 4'd15; run_std("L15", 8, 1);

    // pause edges 6..15: base at 4,18,22; fall_cnt kept so fall at 22
    do_reset("PAUSE");
    for (int e = 1; e <= 22; e++) begin
      enable = !(e >= 6 && e <= 15);
      edge_chk("PAUSE", e, (e == 4 || e == 18 || e == 22), (e == 22));
      if (e == 10) chk("PAUSE hold phase", 32'(base_phase), 32'd1);
      if (e == 18) chk("PAUSE phase e18", 32'(base_phase), 32'd0);
    end

    // soft drop over edges 5..8: fall at 8, then 3 base ticks to 20
    do_reset("SOFT");
    enable = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      soft_drop = (e >= 5 && e <= 8);
      edge_chk("SOFT", e, (e % 4 == 0), (e == 8 || e == 20));
    end
    soft_drop = 1'b0;

    // divisor drop with fall_cnt=2: fall at 12, then every 2nd base (20)
    do_reset("DEC");
    enable = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      level = (e >= 9) ? 4'd1 : 4'd0;
      edge_chk("DEC", e, (e % 4 == 0), (e == 12 || e == 20));
    end

    // restart at edge 10 with enable high: base at 14,18,22; fall_cnt cleared so fall at 22
    do_reset("RST");
    enable = 1'b1;
    for (int e = 1; e <= 22; e++) begin
      restart = (e == 10);
      edge_chk("RST", e, (e == 4 || e == 8 || e == 14 || e == 18 || e == 22), (e == 22));
      if (e == 14) chk("RST phase e14", 32'(base_phase), 32'd1);
    end
    restart = 1'b0;

    // async reset pulse between edges
    do_reset("ARST");
    enable = 1'b1;
    for (int e = 1; e <= 4; e++) edge_chk("ARST pre", e, (e == 4), 1'b0);
    #2 reset = 1'b1;
    #1 chk("ARST immediate", 32'({base_tick, base_phase}), 32'd0);
    #3 reset = 1'b0;
    for (int e = 1; e <= 4; e++) edge_chk("ARST post", e, (e == 4), 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
